// File: rtl/uart_rx_deglitch.sv
// ---------------------------------------------------------------------------
// uart_rx_deglitch
//
// Conditions a raw asynchronous serial line before it reaches a UART
// receiver. The line is passed through a two-flop synchroniser and then a
// run-length debouncer. A level change reaches sig_out only after the
// synchronised line has disagreed with sig_out for STABLE consecutive
// clocks. A shorter excursion is dropped, and each dropped excursion is
// reported as a glitch. In bypass mode (en=0) the synchronised line is
// passed straight through.
//
// Parameters
//   STABLE       consecutive differing samples needed to flip sig_out (>=2)
//   CNT_W        width of the saturating glitch counter
//
// Ports
//   clk          single clock, rising edge
//   rst          asynchronous active-high reset
//   en           1 = filter active, 0 = bypass
//   clr          synchronous clear of glitch_cnt (wins over an increment)
//   sig_in       raw line from the channel, idle high, asynchronous
//   sig_out      conditioned line towards the UART rx_channel_in
//   glitch_pulse one-cycle strobe per suppressed glitch
//   glitch_cnt   saturating count of suppressed glitches
// ---------------------------------------------------------------------------
module uart_rx_deglitch #(
    parameter int STABLE = 3,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             sig_in,
    output logic             sig_out,
    output logic             glitch_pulse,
    output logic [CNT_W-1:0] glitch_cnt
);

    localparam int RUN_W = (STABLE > 1) ? $clog2(STABLE) : 1;
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(STABLE - 1);
    localparam logic [RUN_W-1:0] RUN_ZERO = {RUN_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic             s1_r;
    logic             s2_r;
    logic [RUN_W-1:0] run_r;
    logic             sig_out_r;
    logic             glitch_pulse_r;
    logic [CNT_W-1:0] glitch_cnt_r;

    logic [RUN_W-1:0] run_s;
    logic             sig_out_s;
    logic             glitch_s;
    logic [CNT_W-1:0] glitch_cnt_s;

    // Next-state of the debouncer: run length, filtered level, glitch detect.
    always_comb begin
        run_s     = run_r;
        sig_out_s = sig_out_r;
        glitch_s  = 1'b0;
        if (!en) begin
            // Bypass drops any partial run silently; it is not a glitch.
            sig_out_s = s2_r;
            run_s     = RUN_ZERO;
        end else if (s2_r != sig_out_r) begin
            if (run_r == RUN_LAST) begin
                sig_out_s = s2_r;
                run_s     = RUN_ZERO;
            end else begin
                run_s = run_r + RUN_W'(1);
            end
        end else if (run_r != RUN_ZERO) begin
            // Line returned to the output level before the run completed.
            run_s    = RUN_ZERO;
            glitch_s = 1'b1;
        end else begin
            run_s = RUN_ZERO;
        end
    end

    // Next value of the saturating glitch counter; clear beats increment.
    always_comb begin
        glitch_cnt_s = glitch_cnt_r;
        if (clr) begin
            glitch_cnt_s = {CNT_W{1'b0}};
        end else if (glitch_s && (glitch_cnt_r != CNT_MAX)) begin
            glitch_cnt_s = glitch_cnt_r + CNT_W'(1);
        end else begin
            glitch_cnt_s = glitch_cnt_r;
        end
    end

    // State registers; reset puts everything into the idle-high condition.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_r           <= 1'b1;
            s2_r           <= 1'b1;
            run_r          <= RUN_ZERO;
            sig_out_r      <= 1'b1;
            glitch_pulse_r <= 1'b0;
            glitch_cnt_r   <= {CNT_W{1'b0}};
        end else begin
            s1_r           <= sig_in;
            s2_r           <= s1_r;
            run_r          <= run_s;
            sig_out_r      <= sig_out_s;
            glitch_pulse_r <= glitch_s;
            glitch_cnt_r   <= glitch_cnt_s;
        end
    end

    assign sig_out      = sig_out_r;
    assign glitch_pulse = glitch_pulse_r;
    assign glitch_cnt   = glitch_cnt_r;

endmodule

// File: doc/uart_rx_deglitch.md
# uart_rx_deglitch

Serial-line conditioner that sits between the channel (noise generator output) and a UART receiver's `rx_channel_in`. It synchronises the raw line, suppresses pulses shorter than `STABLE` clocks with a run-length debouncer, and counts each suppressed glitch. The UART receiver therefore sees a clean, fixed-latency copy of the line. A bypass mode passes the synchronised line through unfiltered.

## Interface
- `STABLE`, 3, consecutive differing samples required before the output flips; legal range ≥2.
- `CNT_W`, 8, width of the glitch counter.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `en`  in  1  1 = filter active; 0 = bypass.
- `clr`  in  1  synchronous clear of `glitch_cnt`.
- `sig_in`  in  1  raw line from channel; asynchronous; idle high.
- `sig_out`  out  1  conditioned line to UART `rx_channel_in`.
- `glitch_pulse`  out  1  one-cycle strobe per suppressed glitch.
- `glitch_cnt`  out  CNT_W  saturating count of suppressed glitches.

## Operation
- Synchroniser:
  - `s1 <= sig_in`, then `s2 <= s1`.
  - Only `s2` feeds the rest of the logic.
- Run counter `run`:
  - Width is `$clog2(STABLE)`; it counts consecutive cycles in which `s2 != sig_out`.
- Filter, `en=1`, evaluated every edge:
  - `s2 != sig_out` and `run == STABLE-1`: `sig_out <= s2`, `run <= 0`, no glitch.
  - `s2 != sig_out` and `run < STABLE-1`: `run <= run+1`.
  - `s2 == sig_out` and `run != 0`: glitch. Set `run <= 0` and `glitch_pulse <= 1`; increment `glitch_cnt` unless it is all-ones (saturate).
  - `s2 == sig_out` and `run == 0`: idle, `glitch_pulse <= 0`.
- `glitch_pulse` is registered and high for exactly one cycle per glitch event.
- Bypass, `en=0`:
  - `sig_out <= s2` and `run <= 0`.
  - `glitch_pulse <= 0`; `glitch_cnt` holds.
- `en` toggling:
  - Takes effect on the next edge.
  - Switching 0→1 starts with `run=0` and `sig_out` equal to the last `s2`.
  - A partial run is discarded on 1→0 and is not counted as a glitch.
- `clr=1`:
  - `glitch_cnt <= 0` on that edge.
  - Clear has priority over a simultaneous increment; `glitch_pulse` still fires for that event.
- Reset (async, any time, including mid-run):
  - `s1=s2=1`, `sig_out=1`, `run=0`, `glitch_pulse=0`, `glitch_cnt=0`.
  - After release, the block behaves as if the line had been idle-high.

## Timing
- Reset values of outputs: `sig_out=1`, `glitch_pulse=0`, `glitch_cnt=0`.
- Edge `k` is the first edge that captures a new `sig_in` level into `s1`.
- Clean transition, `en=1`:
  - `sig_out` changes at edge `k+STABLE+1`; for `STABLE=3` that is edge `k+4`.
  - Latency is constant for both polarities.
- Pulse of width `w` cycles (captured at edges `k..k+w-1`), `en=1`:
  - `w < STABLE`: `sig_out` unchanged. `glitch_pulse` is set at edge `k+w+2` (high for the following cycle), and `glitch_cnt` increments at that same edge.
  - `w ≥ STABLE`: passes through delayed by `STABLE+1` cycles, with no glitch.
- Bypass latency: `sig_out` follows at edge `k+2`.
- Minimum passed pulse width is `STABLE` cycles. The UART bit period must be ≥ `STABLE+1` clocks for lossless operation.

## Test plan
- Reset and idle:
  - Assert `rst` with `sig_in=0`: `sig_out=1`, `glitch_cnt=0`, `glitch_pulse=0` immediately.
  - Release and hold `sig_in=1` for 20 cycles: outputs stay at reset values.
- Clean edges, `STABLE=3`, `en=1`:
  - Drop `sig_in` at edge k: `sig_out` falls at edge k+4.
  - Raise at edge k+10: `sig_out` rises at k+14.
  - `glitch_cnt` stays 0 throughout.
- Short glitches on an idle-high line:
  - 1-cycle low pulse: `sig_out` stays 1; `glitch_pulse` is set at edge k+3; `glitch_cnt=1`.
  - Then a 2-cycle pulse: `glitch_cnt=2`.
  - Then a 3-cycle pulse: passes (low for 3 cycles, starting edge k+4), `glitch_cnt` still 2.
- Saturation and clear, `CNT_W=2`:
  - 5 isolated 1-cycle glitches: `glitch_cnt` sequence 1, 2, 3, 3, 3 with 5 `glitch_pulse` strobes.
  - `clr` on the same edge as a 6th glitch: `glitch_cnt=0`, `glitch_pulse=1`.
- Bypass and en switching:
  - `en=0` with a 1-cycle pulse: `sig_out` mirrors it 2 cycles later, count unchanged.
  - Drop `en` mid-run (`run=2`): no glitch counted.
- Reset mid-operation:
  - Assert `rst` while `sig_out=0` and `run=1`: `sig_out=1` and counters zero asynchronously.
  - After release with `sig_in=0`: `sig_out` falls exactly `STABLE+1` edges after the first capturing edge.
